// File: rtl/booth_r4_mult_seq.sv
// rtl/booth_r4_mult_seq.sv - sequential radix-4 Booth multiplier with valid/ready handshakes
//
// Purpose: multiplies two WIDTH-bit operands, signed or unsigned per operation,
// retiring two multiplier bits per cycle. The result is held in a shadow register
// until the consumer accepts it.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   operand handshake; in_ready is high only while idle
//   is_signed, a, b     operation mode, multiplicand, multiplier (sampled on acceptance)
//   out_valid/out_ready result handshake; result held while out_ready is low
//   product             exact 2*WIDTH-bit product
//   out_signed          mode of the operation that produced product
//   busy                high while an operation is running or waiting to be taken

module booth_r4_mult_seq #(
  parameter int WIDTH = 32,
  localparam int PW = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PW-1:0]    product,
  output logic             out_signed,
  output logic             busy
);

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
      $error("booth_r4_mult_seq: WIDTH must be even and >= 4");
    end
  endgenerate

  // Extended datapath width: two guard bits hold +/-2A for either operand mode.
  localparam int XW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH / 2 + 2);
  localparam logic [CW-1:0] STEPS_SIGNED   = CW'(WIDTH / 2);
  localparam logic [CW-1:0] STEPS_UNSIGNED = CW'(WIDTH / 2 + 1);
  localparam logic [CW-1:0] LAST_STEP      = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   a_q, a_d;
  // Multiplier with the implicit zero below the LSB at bit 0.
  logic [XW:0]     b_q, b_d;
  logic [XW-1:0]   acc_q, acc_d;
  logic [XW-1:0]   lo_q, lo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            signed_q, signed_d;
  logic [PW-1:0]   product_q, product_d;
  logic            out_signed_q, out_signed_d;

  logic [2:0]      triplet;
  logic            dig_zero;
  logic            dig_two;
  logic            dig_neg;
  logic [XW-1:0]   magnitude;
  logic [XW-1:0]   pp_op;
  logic            pp_cin;
  logic [XW-1:0]   sum;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == LAST_STEP) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready   = (state_q == ST_IDLE);
    out_valid  = (state_q == ST_DONE);
    busy       = (state_q != ST_IDLE);
    product    = product_q;
    out_signed = out_signed_q;
  end

  // Booth digit decode of {b[i+1], b[i], b[i-1]}
  assign triplet = b_q[2:0];

  always_comb begin
    dig_zero = 1'b0;
    dig_two  = 1'b0;
    dig_neg  = 1'b0;
    case (triplet)
      3'b000, 3'b111: dig_zero = 1'b1;
      3'b001, 3'b010: dig_zero = 1'b0;
      3'b011:         dig_two  = 1'b1;
      3'b100: begin
        dig_two = 1'b1;
        dig_neg = 1'b1;
      end
      3'b101, 3'b110: dig_neg = 1'b1;
      default:        dig_zero = 1'b1;
    endcase
  end

  // Negative digits add the inverted magnitude plus a carry-in of one.
  assign magnitude = dig_two ? {a_q[XW-2:0], 1'b0} : a_q;
  assign pp_op     = dig_zero ? '0 : (dig_neg ? ~magnitude : magnitude);
  assign pp_cin    = dig_neg & ~dig_zero;
  // Carry out of the top bit is dropped; the true partial sum always fits XW signed bits.
  assign sum       = acc_q + pp_op + XW'(pp_cin);

  // Datapath next-state
  always_comb begin
    a_d          = a_q;
    b_d          = b_q;
    acc_d        = acc_q;
    lo_d         = lo_q;
    cnt_d        = cnt_q;
    signed_d     = signed_q;
    product_d    = product_q;
    out_signed_d = out_signed_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d      = is_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
          b_d      = is_signed ? {{2{b[WIDTH-1]}}, b, 1'b0} : {2'b00, b, 1'b0};
          signed_d = is_signed;
          acc_d    = '0;
          lo_d     = '0;
          cnt_d    = is_signed ? STEPS_SIGNED : STEPS_UNSIGNED;
        end
      end
      ST_RUN: begin
        acc_d = {{2{sum[XW-1]}}, sum[XW-1:2]};
        lo_d  = {sum[1:0], lo_q[XW-1:2]};
        b_d   = {{2{b_q[XW]}}, b_q[XW:2]};
        cnt_d = cnt_q - LAST_STEP;
        if (cnt_q == LAST_STEP) begin
          // Signed runs shift out WIDTH low bits, unsigned runs WIDTH+2.
          product_d    = signed_q ? {acc_d[WIDTH-1:0], lo_d[XW-1:2]}
                                  : {acc_d[WIDTH-3:0], lo_d};
          out_signed_d = signed_q;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q          <= '0;
      b_q          <= '0;
      acc_q        <= '0;
      lo_q         <= '0;
      cnt_q        <= '0;
      signed_q     <= 1'b0;
      product_q    <= '0;
      out_signed_q <= 1'b0;
    end else begin
      a_q          <= a_d;
      b_q          <= b_d;
      acc_q        <= acc_d;
      lo_q         <= lo_d;
      cnt_q        <= cnt_d;
      signed_q     <= signed_d;
      product_q    <= product_d;
      out_signed_q <= out_signed_d;
    end
  end

endmodule

// File: tb/tb_booth_r4_mult_seq.sv
// tb/tb_booth_r4_mult_seq.sv - self-checking bench for booth_r4_mult_seq at WIDTH 32 and 8

module tb_booth_r4_mult_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        iv32, ir32, s32, ov32, or32, os32, busy32;
  logic [31:0] a32, b32;
  logic [63:0] p32;

  logic        iv8, ir8, s8, ov8, or8, os8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  int n_checks = 0;
  int n_fail   = 0;

  booth_r4_mult_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .is_signed(s32),
    .a(a32), .b(b32), .out_valid(ov32), .out_ready(or32), .product(p32),
    .out_signed(os32), .busy(busy32)
  );

  booth_r4_mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .is_signed(s8),
    .a(a8), .b(b8), .out_valid(ov8), .out_ready(or8), .product(p8),
    .out_signed(os8), .busy(busy8)
  );

  function automatic logic [63:0] ref32(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint x, y;
    x = s ? {{32{a[31]}}, a} : {32'd0, a};
    y = s ? {{32{b[31]}}, b} : {32'd0, b};
    return x * y;
  endfunction

  function automatic logic [15:0] ref8(input logic s, input logic [7:0] a, input logic [7:0] b);
    int x, y;
    logic [31:0] r;
    x = s ? {{24{a[7]}}, a} : {24'd0, a};
    y = s ? {{24{b[7]}}, b} : {24'd0, b};
    r = x * y;
    return r[15:0];
  endfunction

  task automatic send32(input logic s, input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    while (ir32 !== 1'b1 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    iv32 = 1'b1; s32 = s; a32 = a; b32 = b;
    @(posedge clk); #1;
    iv32 = 1'b0; s32 = ~s; a32 = $urandom; b32 = $urandom;
  endtask

  task automatic wait_out32(output int lat);
    lat = 0;
    while (ov32 !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain32();
    or32 = 1'b1;
    @(posedge clk); #1;
    or32 = 1'b0;
  endtask

  task automatic op8(input logic s, input logic [7:0] a, input logic [7:0] b,
                     input int gap_in, input int gap_out,
                     output int lat, output logic [15:0] p, output logic ps);
    int guard = 0;
    repeat (gap_in) begin
      iv8 = 1'b0; a8 = 8'($urandom);
      @(posedge clk); #1;
    end
    while (ir8 !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    iv8 = 1'b1; s8 = s; a8 = a; b8 = b;
    @(posedge clk); #1;
    iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 0;
    while (ov8 !== 1'b1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    repeat (gap_out) begin
      iv8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
      @(posedge clk); #1;
    end
    p  = p8;
    ps = os8;
    iv8 = 1'b0; or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    iv32 = 1'b0; s32 = 1'b0; a32 = '0; b32 = '0; or32 = 1'b0;
    iv8 = 1'b0; s8 = 1'b0; a8 = '0; b8 = '0; or8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (ir32 !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b expected 1", ir32); end
    n_checks++; if (ov32 !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b expected 0", ov32); end
    n_checks++; if (busy32 !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", busy32); end
    n_checks++; if (p32 !== 64'd0) begin n_fail++; $display("FAIL reset product: got %h expected 0", p32); end
    n_checks++; if (os32 !== 1'b0) begin n_fail++; $display("FAIL reset out_signed: got %b expected 0", os32); end
    n_checks++; if (ir8 !== 1'b1 || ov8 !== 1'b0 || p8 !== 16'd0) begin
      n_fail++; $display("FAIL reset w8: got ir=%b ov=%b p=%h expected 1 0 0000", ir8, ov8, p8);
    end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (ir32 !== 1'b1 || busy32 !== 1'b0) begin
      n_fail++; $display("FAIL post-reset idle: got ir=%b busy=%b expected 1 0", ir32, busy32);
    end
  endtask

  task automatic test_corner32();
    logic        cs [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ca [5] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] cb [5] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000001};
    logic [63:0] cp [5] = '{64'h4000000000000000, 64'hFFFFFFFE00000001, 64'h0000000000000001,
                            64'h00000000FFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
    int          cl [5] = '{16, 17, 16, 17, 16};
    int lat;
    for (int i = 0; i < 5; i++) begin
      send32(cs[i], ca[i], cb[i]);
      wait_out32(lat);
      n_checks++; if (p32 !== cp[i]) begin n_fail++; $display("FAIL corner%0d product: got %h expected %h", i, p32, cp[i]); end
      n_checks++; if (lat != cl[i]) begin n_fail++; $display("FAIL corner%0d latency: got %0d expected %0d", i, lat, cl[i]); end
      n_checks++; if (os32 !== cs[i]) begin n_fail++; $display("FAIL corner%0d out_signed: got %b expected %b", i, os32, cs[i]); end
      drain32();
    end
  endtask

  task automatic test_random32();
    logic s;
    logic [31:0] a, b;
    logic [63:0] exp_p;
    int lat, exp_lat;
    for (int i = 0; i < 60; i++) begin
      s = 1'($urandom);
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) a = {a[31], 31'd0};
      exp_p = ref32(s, a, b);
      exp_lat = 32 / 2 + (s ? 0 : 1);
      send32(s, a, b);
      wait_out32(lat);
      n_checks++; if (p32 !== exp_p) begin n_fail++; $display("FAIL rand32 product s=%b a=%h b=%h: got %h expected %h", s, a, b, p32, exp_p); end
      n_checks++; if (lat != exp_lat) begin n_fail++; $display("FAIL rand32 latency: got %0d expected %0d", lat, exp_lat); end
      n_checks++; if (os32 !== s) begin n_fail++; $display("FAIL rand32 out_signed: got %b expected %b", os32, s); end
      drain32();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, na, nb;
    logic [63:0] exp_p;
    int lat;
    a = $urandom | 32'h1; b = $urandom | 32'h1;
    na = $urandom; nb = $urandom;
    exp_p = ref32(1'b1, a, b);
    send32(1'b1, a, b);
    wait_out32(lat);
    n_checks++; if (lat != 16) begin n_fail++; $display("FAIL bp latency: got %0d expected 16", lat); end
    for (int i = 0; i < 20; i++) begin
      or32 = 1'b0; iv32 = ~iv32; a32 = $urandom; b32 = $urandom; s32 = 1'($urandom);
      @(posedge clk); #1;
      n_checks++; if (p32 !== exp_p) begin n_fail++; $display("FAIL bp hold product cyc%0d: got %h expected %h", i, p32, exp_p); end
      n_checks++; if (ov32 !== 1'b1 || ir32 !== 1'b0 || busy32 !== 1'b1) begin
        n_fail++; $display("FAIL bp hold flags cyc%0d: got ov=%b ir=%b busy=%b expected 1 0 1", i, ov32, ir32, busy32);
      end
    end
    iv32 = 1'b1; s32 = 1'b0; a32 = na; b32 = nb; or32 = 1'b1;
    @(posedge clk); #1;
    or32 = 1'b0;
    n_checks++; if (ov32 !== 1'b0 || ir32 !== 1'b1 || busy32 !== 1'b0) begin
      n_fail++; $display("FAIL bp release idle: got ov=%b ir=%b busy=%b expected 0 1 0", ov32, ir32, busy32);
    end
    @(posedge clk); #1;
    iv32 = 1'b0; a32 = $urandom; b32 = $urandom; s32 = 1'b1;
    n_checks++; if (busy32 !== 1'b1 || ir32 !== 1'b0) begin
      n_fail++; $display("FAIL bp next accept: got busy=%b ir=%b expected 1 0", busy32, ir32);
    end
    wait_out32(lat);
    n_checks++; if (lat != 17) begin n_fail++; $display("FAIL bp next latency: got %0d expected 17", lat); end
    n_checks++; if (p32 !== ref32(1'b0, na, nb)) begin
      n_fail++; $display("FAIL bp next product: got %h expected %h", p32, ref32(1'b0, na, nb));
    end
    drain32();
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] a, b;
    int lat;
    bit seen_ov = 0;
    send32(1'b0, $urandom, $urandom);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if (ov32 !== 1'b0) begin n_fail++; $display("FAIL midrst out_valid: got %b expected 0", ov32); end
    n_checks++; if (ir32 !== 1'b1) begin n_fail++; $display("FAIL midrst in_ready: got %b expected 1", ir32); end
    n_checks++; if (p32 !== 64'd0) begin n_fail++; $display("FAIL midrst product: got %h expected 0", p32); end
    n_checks++; if (busy32 !== 1'b0 || os32 !== 1'b0) begin
      n_fail++; $display("FAIL midrst busy/out_signed: got %b %b expected 0 0", busy32, os32);
    end
    #1 rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (ov32 === 1'b1) seen_ov = 1;
    end
    n_checks++; if (seen_ov) begin n_fail++; $display("FAIL midrst aborted op emitted: got out_valid 1 expected 0"); end
    a = $urandom; b = $urandom;
    send32(1'b1, a, b);
    wait_out32(lat);
    n_checks++; if (p32 !== ref32(1'b1, a, b)) begin
      n_fail++; $display("FAIL midrst next product: got %h expected %h", p32, ref32(1'b1, a, b));
    end
    n_checks++; if (lat != 16) begin n_fail++; $display("FAIL midrst next latency: got %0d expected 16", lat); end
    drain32();
  endtask

  task automatic test_w8();
    logic [7:0] edge_v [8] = '{8'h00, 8'h01, 8'h02, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF};
    logic s, ps;
    logic [7:0] a, b;
    logic [15:0] p, exp_p;
    int lat, exp_lat;
    for (int k = 0; k < 128 + 1500; k++) begin
      if (k < 128) begin
        s = k[6];
        a = edge_v[k[5:3]];
        b = edge_v[k[2:0]];
      end else begin
        s = 1'($urandom);
        a = 8'($urandom);
        b = 8'($urandom);
      end
      exp_p = ref8(s, a, b);
      exp_lat = 8 / 2 + (s ? 0 : 1);
      op8(s, a, b, $urandom_range(0, 2), $urandom_range(0, 2), lat, p, ps);
      n_checks++; if (p !== exp_p) begin n_fail++; $display("FAIL w8 product s=%b a=%h b=%h: got %h expected %h", s, a, b, p, exp_p); end
      n_checks++; if (lat != exp_lat) begin n_fail++; $display("FAIL w8 latency s=%b: got %0d expected %0d", s, lat, exp_lat); end
      n_checks++; if (ps !== s) begin n_fail++; $display("FAIL w8 out_signed: got %b expected %b", ps, s); end
    end
  endtask

  initial begin
    test_reset();
    test_corner32();
    test_random32();
    test_backpressure();
    test_reset_mid_run();
    test_w8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
